// File: rtl/auth_cmd_tx.sv
// Authentication command transmitter: serialises 'G'/'S' command bytes as 8N1 UART,
// holds one pending request and re-sends 'G' as a keep-alive while the link is up.
module auth_cmd_tx #(
  parameter int unsigned BAUD_DIV  = 2604,
  parameter int unsigned KA_PERIOD = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go_req,
  input  logic stop_req,
  output logic TX,
  output logic busy,
  output logic cmd_done,
  output logic link_up
);

  localparam logic [7:0]  CmdGo    = 8'h47;
  localparam logic [7:0]  CmdStop  = 8'h53;
  localparam logic [11:0] BaudLast = 12'(BAUD_DIV - 1);
  localparam logic [23:0] KaLimit  = 24'(KA_PERIOD);
  localparam bit          KaEn     = (KA_PERIOD != 0);

  typedef enum logic {StIdle, StXmit} state_e;

  state_e      state_q, state_d;
  logic [11:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [8:0]  shreg_q, shreg_d;
  logic        is_stop_q, is_stop_d;
  logic        pend_q, pend_d;
  logic        pend_stop_q, pend_stop_d;
  logic [23:0] ka_q, ka_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        link_q, link_d;

  logic req;
  logic ka_fire;
  logic start_stop;

  assign req     = go_req | stop_req;
  // Counter sits at KaLimit for one cycle (the decision cycle) before the frame starts.
  assign ka_fire = KaEn && link_q && (ka_q == KaLimit);

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    is_stop_d   = is_stop_q;
    pend_d      = pend_q;
    pend_stop_d = pend_stop_q;
    ka_d        = ka_q;
    tx_d        = tx_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    link_d      = link_q;
    start_stop  = 1'b0;

    case (state_q)
      StIdle: begin
        if (req || pend_q || ka_fire) begin
          // A fresh request beats the pending slot, which beats the keep-alive.
          start_stop  = req ? stop_req : (pend_q & pend_stop_q);
          state_d     = StXmit;
          is_stop_d   = start_stop;
          shreg_d     = {1'b1, start_stop ? CmdStop : CmdGo};
          baud_d      = '0;
          bit_d       = '0;
          tx_d        = 1'b0;
          busy_d      = 1'b1;
          pend_d      = 1'b0;
          pend_stop_d = 1'b0;
          ka_d        = '0;
        end else if (link_q && KaEn) begin
          ka_d = ka_q + 24'd1;
        end else begin
          ka_d = '0;
        end
      end

      StXmit: begin
        if (req) begin
          pend_d      = 1'b1;
          pend_stop_d = stop_req;
        end
        if (baud_q == BaudLast) begin
          baud_d = '0;
          if (bit_q == 4'd9) begin
            state_d = StIdle;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            link_d  = ~is_stop_q;
          end else begin
            bit_d   = bit_q + 4'd1;
            tx_d    = shreg_q[0];
            shreg_d = {1'b1, shreg_q[8:1]};
          end
        end else begin
          baud_d = baud_q + 12'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      baud_q      <= '0;
      bit_q       <= '0;
      shreg_q     <= '1;
      is_stop_q   <= 1'b0;
      pend_q      <= 1'b0;
      pend_stop_q <= 1'b0;
      ka_q        <= '0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      link_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      is_stop_q   <= is_stop_d;
      pend_q      <= pend_d;
      pend_stop_q <= pend_stop_d;
      ka_q        <= ka_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      link_q      <= link_d;
    end
  end

  assign TX       = tx_q;
  assign busy     = busy_q;
  assign cmd_done = done_q;
  assign link_up  = link_q;

endmodule

// File: tb/tb_auth_cmd_tx.sv
// Bench for auth_cmd_tx: directed vector table, multi-cycle sequences and random stimulus
// checked cycle by cycle against a frame-level reference model.
module tb_auth_cmd_tx;

  localparam int Baud     = 4;
  localparam int Ka       = 100;
  localparam int FrameLen = 10 * Baud;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic go_req = 1'b0;
  logic stop_req = 1'b0;
  logic tx, busy, cmd_done, link_up;
  logic tx0, busy0, done0, link0;

  always #5 clk = ~clk;

  auth_cmd_tx #(.BAUD_DIV(Baud), .KA_PERIOD(Ka)) u_dut (
    .clk(clk), .rst_n(rst_n), .go_req(go_req), .stop_req(stop_req),
    .TX(tx), .busy(busy), .cmd_done(cmd_done), .link_up(link_up)
  );

  auth_cmd_tx #(.BAUD_DIV(Baud), .KA_PERIOD(0)) u_dut_noka (
    .clk(clk), .rst_n(rst_n), .go_req(go_req), .stop_req(stop_req),
    .TX(tx0), .busy(busy0), .cmd_done(done0), .link_up(link0)
  );

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a frame is FrameLen cycles whose bit index is elapsed / Baud.
  typedef struct {
    bit       busy;
    int       el;
    bit [7:0] data;
    bit       link;
    bit       pend;
    bit       pend_stop;
    int       ka;
    bit       done;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t z;
    z.busy = 0; z.el = 0; z.data = 0; z.link = 0;
    z.pend = 0; z.pend_stop = 0; z.ka = 0; z.done = 0;
    return z;
  endfunction

  function automatic model_t model_next(model_t s, bit go, bit stop, int ka_period);
    model_t n = s;
    bit req = go | stop;
    n.done = 0;
    if (s.busy) begin
      if (req) begin
        n.pend = 1;
        n.pend_stop = stop;
      end
      if (s.el == FrameLen - 1) begin
        n.busy = 0;
        n.done = 1;
        n.link = (s.data == 8'h47);
      end else begin
        n.el = s.el + 1;
      end
    end else if (req || s.pend || (ka_period != 0 && s.link && s.ka == ka_period)) begin
      n.data = (req ? stop : (s.pend && s.pend_stop)) ? 8'h53 : 8'h47;
      n.busy = 1;
      n.el = 0;
      n.pend = 0;
      n.ka = 0;
    end else begin
      n.ka = (s.link && ka_period != 0) ? s.ka + 1 : 0;
    end
    return n;
  endfunction

  function automatic bit model_tx(model_t s);
    int idx;
    if (!s.busy) return 1'b1;
    idx = s.el / Baud;
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return s.data[idx - 1];
  endfunction

  bit chk_en = 0;

  initial m = model_reset();

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) m = model_reset();
    else m = model_next(m, go_req, stop_req, Ka);
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(negedge clk);
    if (rst_n && chk_en)
      check("model", {28'd0, tx, busy, cmd_done, link_up},
            {28'd0, model_tx(m), m.busy, m.done, m.link});
  end

  // Passive line monitor: decodes frames mid-bit and logs start and done cycles.
  int          fr_start[$];
  logic [7:0]  fr_byte[$];
  int          done_cyc[$];
  int          done0_cnt = 0;

  initial begin
    bit         act;
    int         st;
    int         pos;
    logic [7:0] b;
    act = 0; st = 0; pos = 0; b = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        act = 0;
      end else begin
        if (cmd_done) done_cyc.push_back(cyc);
        if (done0) done0_cnt++;
        if (!act && tx == 1'b0) begin
          act = 1;
          st = cyc;
        end
        if (act) begin
          pos = cyc - st;
          if (pos % Baud == Baud / 2 && pos / Baud >= 1 && pos / Baud <= 8)
            b[pos / Baud - 1] = tx;
          if (pos == FrameLen - 1) begin
            fr_start.push_back(st);
            fr_byte.push_back(b);
            act = 0;
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input bit g, input bit s);
    go_req = g;
    stop_req = s;
    tick(1);
    go_req = 1'b0;
    stop_req = 1'b0;
  endtask

  typedef struct {
    bit         go;
    bit         stop;
    logic [7:0] exp_byte;
    bit         exp_link;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int   n, k, d, c0, r;
    logic bad;

    vecs[0] = '{go: 1'b1, stop: 1'b0, exp_byte: 8'h47, exp_link: 1'b1};
    vecs[1] = '{go: 1'b0, stop: 1'b1, exp_byte: 8'h53, exp_link: 1'b0};
    vecs[2] = '{go: 1'b1, stop: 1'b1, exp_byte: 8'h53, exp_link: 1'b0};
    vecs[3] = '{go: 1'b1, stop: 1'b0, exp_byte: 8'h47, exp_link: 1'b1};
    vecs[4] = '{go: 1'b1, stop: 1'b0, exp_byte: 8'h47, exp_link: 1'b1};
    vecs[5] = '{go: 1'b1, stop: 1'b1, exp_byte: 8'h53, exp_link: 1'b0};
    vecs[6] = '{go: 1'b0, stop: 1'b1, exp_byte: 8'h53, exp_link: 1'b0};

    // Reset, then idle.
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset_vals", {28'd0, tx, busy, cmd_done, link_up}, 32'h8);
    check("reset_vals_noka", {28'd0, tx0, busy0, done0, link0}, 32'h8);
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1;
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      bad = bad | !tx | busy | cmd_done | link_up;
    end
    check("reset_idle", {31'd0, bad}, 32'd0);
    check("reset_idle_frames", fr_start.size() + done_cyc.size(), 0);

    // Vector table: single requests from idle.
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      n = cyc;
      k = fr_start.size();
      d = done_cyc.size();
      pulse(vecs[i].go, vecs[i].stop);
      repeat (42) @(negedge clk);
      check("vec_nframes", fr_start.size(), k + 1);
      check("vec_start", (fr_start.size() > k) ? fr_start[k] : -1, n + 1);
      check("vec_byte", (fr_byte.size() > k) ? {24'd0, fr_byte[k]} : 32'hx,
            {24'd0, vecs[i].exp_byte});
      check("vec_done", (done_cyc.size() > d) ? done_cyc[d] : -1, n + 41);
      check("vec_link", {31'd0, link_up}, {31'd0, vecs[i].exp_link});
      check("vec_link_noka", {31'd0, link0}, {31'd0, vecs[i].exp_link});
    end

    // Queued requests during a 'G' frame: go then stop, only the stop survives.
    @(posedge clk);
    #1;
    n = cyc;
    k = fr_start.size();
    pulse(1'b1, 1'b0);
    tick(10);
    pulse(1'b1, 1'b0);
    tick(2);
    pulse(1'b0, 1'b1);
    tick(150);
    check("queue_nframes", fr_start.size(), k + 2);
    check("queue_byte0", (fr_byte.size() > k) ? {24'd0, fr_byte[k]} : 32'hx, 32'h47);
    check("queue_byte1", (fr_byte.size() > k + 1) ? {24'd0, fr_byte[k + 1]} : 32'hx, 32'h53);
    check("queue_b2b_start", (fr_start.size() > k + 1) ? fr_start[k + 1] : -1, n + 42);
    check("queue_link", {31'd0, link_up}, 32'd0);

    // Keep-alive: two 'G' re-sends at E+101 and 141 cycles later, none after a stop.
    n = cyc;
    k = fr_start.size();
    c0 = done0_cnt;
    pulse(1'b1, 1'b0);
    tick(n + 330 - cyc);
    check("ka_nframes", fr_start.size(), k + 3);
    check("ka_start1", (fr_start.size() > k + 1) ? fr_start[k + 1] : -1, n + 142);
    check("ka_start2", (fr_start.size() > k + 2) ? fr_start[k + 2] : -1, n + 283);
    check("ka_byte", (fr_byte.size() > k + 2) ? {24'd0, fr_byte[k + 2]} : 32'hx, 32'h47);
    check("ka_link", {31'd0, link_up}, 32'd1);
    pulse(1'b0, 1'b1);
    tick(300);
    check("ka_after_stop", fr_start.size(), k + 4);
    check("ka_stop_byte", (fr_byte.size() > k + 3) ? {24'd0, fr_byte[k + 3]} : 32'hx, 32'h53);
    check("ka_stop_link", {31'd0, link_up}, 32'd0);
    check("noka_frames", done0_cnt - c0, 2);
    check("noka_link", {31'd0, link0}, 32'd0);

    // Random requests against the model.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 999));
      go_req = (r < 20) || (r >= 995);
      stop_req = (r >= 20 && r < 28) || (r >= 995);
      tick(1);
    end
    go_req = 1'b0;
    stop_req = 1'b0;

    // Reset in the middle of data bit 4 of a 'G' frame.
    for (int i = 0; i < 200 && busy; i++) tick(1);
    check("wait_idle", {31'd0, busy}, 32'd0);
    n = cyc;
    k = fr_start.size();
    pulse(1'b1, 1'b0);
    tick(n + 22 - cyc);
    check("mid_bit4", {30'd0, tx, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {28'd0, tx, busy, cmd_done, link_up}, 32'h8);
    tick(2);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bad = bad | !tx | busy | cmd_done | link_up;
    end
    check("post_reset_idle", {31'd0, bad}, 32'd0);
    check("post_reset_frames", fr_start.size(), k);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
